// File: rtl/imem_arbiter_pkg.sv
// Shared constants and types for the instruction-memory read-port arbiter.
package imem_arbiter_pkg;

  localparam int QWORD             = 64;
  localparam int BYTE              = 8;
  localparam int IMEM_WIN_W        = 10 * BYTE;
  localparam int STARVE_LIMIT_DFLT = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_F    = 2'd1,
    GNT_D    = 2'd2
  } grant_e;

  typedef struct packed {
    logic [IMEM_WIN_W-1:0] bytes;
    logic                  err;
  } imem_resp_t;

endpackage

// File: rtl/imem_resp_slot.sv
// One response register with a valid/ready handshake; reloads on the
// same edge it is consumed when a new grant arrives.
module imem_resp_slot
  import imem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       resp_ready_i,
  input  imem_resp_t mem_resp_i,
  output logic       slot_free_o,
  output logic       resp_valid_o,
  output imem_resp_t resp_o
);

  logic       valid_q, valid_d;
  imem_resp_t data_q, data_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = mem_resp_i;
    end else if (resp_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: the data register is reset too, so outputs read as zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign slot_free_o  = !valid_q || resp_ready_i;
  assign resp_valid_o = valid_q;
  assign resp_o       = data_q;

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates the Y86 instruction-memory read port between fetch (F) and a
// debug reader (D). The D port is active only when IMEM_DBG_PORT_EN is defined.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DFLT,
  parameter int CNT_W        = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  f_req_valid,
  input  logic [QWORD-1:0]      f_req_addr,
  output logic                  f_req_ready,
  output logic                  f_resp_valid,
  input  logic                  f_resp_ready,
  output logic [IMEM_WIN_W-1:0] f_resp_bytes,
  output logic                  f_resp_err,
  input  logic                  d_req_valid,
  input  logic [QWORD-1:0]      d_req_addr,
  output logic                  d_req_ready,
  output logic                  d_resp_valid,
  input  logic                  d_resp_ready,
  output logic [IMEM_WIN_W-1:0] d_resp_bytes,
  output logic                  d_resp_err,
  output logic [QWORD-1:0]      mem_addr,
  input  logic [IMEM_WIN_W-1:0] mem_bytes,
  input  logic                  mem_err
);

  grant_e     grant;
  logic       f_free, f_elig;
  imem_resp_t mem_resp, f_resp;

  assign mem_resp = '{bytes: mem_bytes, err: mem_err};
  assign f_elig   = f_req_valid && f_free;

  imem_resp_slot u_f_slot (
    .clk         (clk),
    .rst         (rst),
    .load_i      (grant == GNT_F),
    .resp_ready_i(f_resp_ready),
    .mem_resp_i  (mem_resp),
    .slot_free_o (f_free),
    .resp_valid_o(f_resp_valid),
    .resp_o      (f_resp)
  );

  assign f_req_ready  = (grant == GNT_F);
  assign f_resp_bytes = f_resp.bytes;
  assign f_resp_err   = f_resp.err;

`ifdef IMEM_DBG_PORT_EN
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic             d_free, d_elig;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  imem_resp_t       d_resp;

  assign d_elig = d_req_valid && d_free;

  // Grants are suppressed while rst is high so ready and mem_addr read as 0.
  always_comb begin
    grant = GNT_NONE;
    if (!rst) begin
      if (d_elig && starve_cnt_q == LIMIT) grant = GNT_D;
      else if (f_elig)                     grant = GNT_F;
      else if (d_elig)                     grant = GNT_D;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant == GNT_D)
      starve_cnt_d = '0;
    else if (grant == GNT_F && d_elig && starve_cnt_q != LIMIT)
      starve_cnt_d = starve_cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_cnt_q <= '0;
    else     starve_cnt_q <= starve_cnt_d;
  end

  imem_resp_slot u_d_slot (
    .clk         (clk),
    .rst         (rst),
    .load_i      (grant == GNT_D),
    .resp_ready_i(d_resp_ready),
    .mem_resp_i  (mem_resp),
    .slot_free_o (d_free),
    .resp_valid_o(d_resp_valid),
    .resp_o      (d_resp)
  );

  assign d_req_ready  = (grant == GNT_D);
  assign d_resp_bytes = d_resp.bytes;
  assign d_resp_err   = d_resp.err;
`else
  always_comb begin
    grant = GNT_NONE;
    if (!rst && f_elig) grant = GNT_F;
  end

  assign d_req_ready  = 1'b0;
  assign d_resp_valid = 1'b0;
  assign d_resp_bytes = '0;
  assign d_resp_err   = 1'b0;

  logic unused_d;
  assign unused_d = ^{d_req_valid, d_req_addr, d_resp_ready};
`endif

  always_comb begin
    mem_addr = '0;
    case (grant)
      GNT_F:   mem_addr = f_req_addr;
      GNT_D:   mem_addr = d_req_addr;
      default: mem_addr = '0;
    endcase
  end

endmodule
